// File: rtl/wb_regfile.sv
// Writeback stage: selects load/ALU data, commits to a 32x XLEN register file (x0 = 0), two combinational read ports.
// Write latency one edge, reads zero cycles; optional WB_BYPASS_EN makes same-cycle reads write-first. No backpressure.
module wb_regfile #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  WB_ReadData,
    input  logic [XLEN-1:0]  WB_ALUResult,
    input  logic [4:0]       WB_Rd,
    input  logic             WB_MemtoReg,
    input  logic             WB_RegWrite,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    output logic [XLEN-1:0]  readdata1,
    output logic [XLEN-1:0]  readdata2,
    output logic [XLEN-1:0]  WB_WriteData,
    output logic [CNT_W-1:0] wb_count
);

    logic [XLEN-1:0]  regs_q [1:31];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             commit;

    assign WB_WriteData = WB_MemtoReg ? WB_ReadData : WB_ALUResult;
    assign commit       = WB_RegWrite && (WB_Rd != 5'd0);
    assign cnt_d        = commit ? cnt_q + 1'b1 : cnt_q;
    assign wb_count     = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            if (commit) begin
                regs_q[WB_Rd] <= WB_WriteData;
            end
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        readdata1 = '0;
        readdata2 = '0;
        if (rs1 != 5'd0) begin
            readdata1 = regs_q[rs1];
        end
        if (rs2 != 5'd0) begin
            readdata2 = regs_q[rs2];
        end
`ifdef WB_BYPASS_EN
        // Write-first: the in-flight commit is visible to ID in the same cycle.
        if (commit && (WB_Rd == rs1)) begin
            readdata1 = WB_WriteData;
        end
        if (commit && (WB_Rd == rs2)) begin
            readdata2 = WB_WriteData;
        end
`endif
    end

endmodule
